// File: rtl/dbus_pkg.sv
// Shared definitions for the cpu32 data-bus responder.
//   - I/O page word offsets (d_addr[7:2]) for TIMER, STATUS and TXDATA
//   - STATUS register bit positions
//   - UART shifter state encoding
package dbus_pkg;

    // Word offsets within the I/O page, i.e. byte offset >> 2.
    localparam logic [5:0] IO_TIMER  = 6'h00;
    localparam logic [5:0] IO_STATUS = 6'h01;
    localparam logic [5:0] IO_TXDATA = 6'h02;

    localparam int unsigned STATUS_FULL = 0;
    localparam int unsigned STATUS_BUSY = 1;
    localparam int unsigned STATUS_OVF  = 2;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } shift_state_e;

endpackage

// File: rtl/uart_tx_shift.sv
// Buffered 8N1 UART transmitter: a small TX FIFO feeding a start/data/stop shifter.
//   clk      : clock, all state updates on the rising edge
//   reset    : synchronous active-high reset
//   push     : enqueue data this edge (ignored when full)
//   data     : byte to enqueue
//   full     : FIFO holds FIFO_DEPTH entries
//   busy     : FIFO non-empty or a frame in progress
//   uart_tx  : serial output, idle high
module uart_tx_shift
    import dbus_pkg::*;
#(
    parameter int unsigned CLKDIV     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] data,
    output logic       full,
    output logic       busy,
    output logic       uart_tx
);

    localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DW   = $clog2(CLKDIV);

    localparam logic [DW-1:0]   DIV_LAST = DW'(CLKDIV - 1);
    localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(FIFO_DEPTH);
    localparam logic [PW-1:0]   PTR_LAST = PW'(FIFO_DEPTH - 1);

    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q;

    shift_state_e    state_q;
    logic [DW-1:0]   div_q;
    logic [2:0]      idx_q;
    logic [7:0]      shreg_q;
    logic            tx_q;

    logic fifo_empty;
    logic push_ok;
    logic bit_end;
    logic pop;

    always_comb begin
        full       = (count_q == DEPTH_C);
        fifo_empty = (count_q == '0);
        // Fullness is judged before any same-edge pop.
        push_ok    = push && !full;
        bit_end    = (div_q == DIV_LAST);
        // Pop from IDLE, or on the last STOP cycle so frames run back to back.
        pop        = !fifo_empty &&
                     ((state_q == StIdle) || ((state_q == StStop) && bit_end));
        busy       = !fifo_empty || (state_q != StIdle);
        uart_tx    = tx_q;
    end

    // FIFO storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CNTW'(push_ok) - CNTW'(pop);
        end
    end

    // tx_q is loaded with the level of the state being entered, so the line
    // changes in the same cycle the FSM changes state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            div_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    div_q <= '0;
                    if (pop) begin
                        shreg_q <= fifo_q[rd_ptr_q];
                        state_q <= StStart;
                        tx_q    <= 1'b0;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        div_q   <= '0;
                        idx_q   <= '0;
                        state_q <= StData;
                        tx_q    <= shreg_q[0];
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                StData: begin
                    if (bit_end) begin
                        div_q <= '0;
                        if (idx_q == 3'd7) begin
                            state_q <= StStop;
                            tx_q    <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            tx_q  <= shreg_q[idx_q + 3'd1];
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        div_q <= '0;
                        if (pop) begin
                            shreg_q <= fifo_q[rd_ptr_q];
                            state_q <= StStart;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus slave for the cpu32 core: word RAM below 0x8000_0000, I/O page above.
//   clk      : clock, all state updates on the rising edge
//   reset    : synchronous active-high reset
//   d_addr   : byte address, bits [1:0] ignored
//   d_data_w : write data
//   d_we     : write strobe, committed on the rising edge
//   d_data_r : combinational read data (core samples it in the same cycle)
//   uart_tx  : UART serial output, idle high
module dbus_responder
    import dbus_pkg::*;
#(
    parameter int unsigned RAM_AW     = 12,
    parameter int unsigned CLKDIV     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_data_w,
    input  logic        d_we,
    output logic [31:0] d_data_r,
    output logic        uart_tx
);

    localparam int unsigned RAM_WORDS = 1 << RAM_AW;

    logic [31:0]       ram_q [RAM_WORDS];
    logic [31:0]       timer_q, timer_d;
    logic              ovf_q, ovf_d;

    logic              is_io;
    logic [5:0]        io_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              wr_ram, wr_timer, wr_status, wr_txdata;
    logic              tx_full, tx_busy;
    logic [31:0]       status;

    // Upper RAM address bits alias and d_addr[1:0] is ignored by design.
    logic unused_addr;
    assign unused_addr = ^{d_addr[30:8], d_addr[1:0]};

    always_comb begin
        is_io     = d_addr[31];
        io_off    = d_addr[7:2];
        ram_idx   = d_addr[RAM_AW+1:2];
        wr_ram    = d_we && !is_io;
        wr_timer  = d_we && is_io && (io_off == IO_TIMER);
        wr_status = d_we && is_io && (io_off == IO_STATUS);
        wr_txdata = d_we && is_io && (io_off == IO_TXDATA);
    end

    uart_tx_shift #(
        .CLKDIV     (CLKDIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_uart_tx_shift (
        .clk     (clk),
        .reset   (reset),
        .push    (wr_txdata),
        .data    (d_data_w[7:0]),
        .full    (tx_full),
        .busy    (tx_busy),
        .uart_tx (uart_tx)
    );

    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram_q[ram_idx] <= d_data_w;
        end
    end

    always_comb begin
        timer_d = wr_timer ? d_data_w : timer_q + 32'd1;
        ovf_d   = ovf_q;
        if (wr_status) begin
            ovf_d = 1'b0;
        end else if (wr_txdata && tx_full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        status              = '0;
        status[STATUS_FULL] = tx_full;
        status[STATUS_BUSY] = tx_busy;
        status[STATUS_OVF]  = ovf_q;

        d_data_r = '0;
        if (!is_io) begin
            d_data_r = ram_q[ram_idx];
        end else begin
            case (io_off)
                IO_TIMER:  d_data_r = timer_q;
                IO_STATUS: d_data_r = status;
                default:   d_data_r = '0;
            endcase
        end
    end

endmodule
